// File: rtl/nn_ctrl_pkg.sv
// Shared types and widths for the NeuralNetwork inference sequencer.
package nn_ctrl_pkg;

   // Default widths of the argmax index and Q8.8 max value.
   localparam int unsigned IDX_W_DEFAULT = 4;
   localparam int unsigned VAL_W_DEFAULT = 16;

   // Width of the watchdog and inference counters.
   localparam int unsigned CNT_W = 16;

   // Width of the NN reset down-counter (RESET_CYCLES is 1..15).
   localparam int unsigned RST_CNT_W = 4;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StNnRst  = 3'd1,
      StSettle = 3'd2,
      StRun    = 3'd3,
      StWait   = 3'd4,
      StDone   = 3'd5
   } state_e;

   // The sequencer counts as busy in every state other than idle.
   function automatic logic state_is_busy(state_e s);
      return s != StIdle;
   endfunction

endpackage

// File: rtl/sync_toggle_edge.sv
// Two-flop synchronizer plus edge detector for an asynchronous toggle
// signal: every level change yields one single-cycle event pulse.
module sync_toggle_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic toggle_i,
   output logic event_o
);

   logic sync1_q;
   logic sync2_q;
   logic last_q;
   logic event_q;

   // Synchronize the toggle, remember the previous level and register the edge pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         last_q  <= 1'b0;
         event_q <= 1'b0;
      end else begin
         sync1_q <= toggle_i;
         sync2_q <= sync1_q;
         last_q  <= sync2_q;
         event_q <= sync2_q ^ last_q;
      end
   end

   assign event_o = event_q;

endmodule

// File: rtl/nn_infer_sequencer.sv
// Sequences one NeuralNetwork inference per trigger: reset pulse, settle,
// input-valid, wait for the argmax result (with watchdog), then capture.
module nn_infer_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter int unsigned IDX_W          = IDX_W_DEFAULT,
   parameter int unsigned VAL_W          = VAL_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             frame_toggle,
   input  logic             start_pulse,
   input  logic             auto_mode,
   input  logic             max_valid,
   input  logic [IDX_W-1:0] max_index,
   input  logic [VAL_W-1:0] max_value,
   output logic             nn_reset,
   output logic             nn_valid,
   output logic [IDX_W-1:0] result_index,
   output logic [VAL_W-1:0] result_value,
   output logic             result_valid,
   output logic             busy,
   output logic             timeout_err,
   output logic [CNT_W-1:0] infer_count
);

   // Load values for the down-counter and the last watchdog count before expiry.
   localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]     WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [RST_CNT_W-1:0] RST_ONE  = RST_CNT_W'(1);

   state_e               state_q;
   logic [RST_CNT_W-1:0] rst_cnt_q;
   logic [CNT_W-1:0]     wd_q;
   logic                 pending_q;
   logic [IDX_W-1:0]     result_index_q;
   logic [VAL_W-1:0]     result_value_q;
   logic                 result_valid_q;
   logic                 timeout_err_q;
   logic [CNT_W-1:0]     infer_count_q;

   logic frame_event;
   logic trigger;
   logic wd_expire;
   logic busy_w;
   logic nn_reset_w;
   logic nn_valid_w;

   sync_toggle_edge u_sync_toggle_edge (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .toggle_i (frame_toggle),
      .event_o  (frame_event)
   );

   // Trigger sources, watchdog expiry and the state-decoded NN handshake.
   always_comb begin
      trigger    = frame_event | start_pulse | (auto_mode & (state_q == StDone));
      wd_expire  = (state_q == StWait) && (wd_q == WD_LAST);
      busy_w     = state_is_busy(state_q);
      nn_reset_w = (state_q == StNnRst);
      // nn_valid drops in the WAIT exit cycle, whether by result or by expiry.
      nn_valid_w = (state_q == StRun) |
                   ((state_q == StWait) & ~max_valid & ~wd_expire);
   end

   // Main sequencer FSM with its counters, pending flag and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         rst_cnt_q      <= '0;
         wd_q           <= '0;
         pending_q      <= 1'b0;
         result_index_q <= '0;
         result_value_q <= '0;
         result_valid_q <= 1'b0;
         timeout_err_q  <= 1'b0;
         infer_count_q  <= '0;
      end else begin
         result_valid_q <= 1'b0;

         // One-deep pending flag; DONE consumes its own trigger directly.
         if (trigger && busy_w && (state_q != StDone)) begin
            pending_q <= 1'b1;
         end

         unique case (state_q)
            StIdle: begin
               if (trigger) begin
                  state_q       <= StNnRst;
                  rst_cnt_q     <= RST_LAST;
                  timeout_err_q <= 1'b0;
                  pending_q     <= 1'b0;
               end
            end
            StNnRst: begin
               if (rst_cnt_q == '0) begin
                  state_q <= StSettle;
               end else begin
                  rst_cnt_q <= rst_cnt_q - RST_ONE;
               end
            end
            StSettle: begin
               state_q <= StRun;
            end
            StRun: begin
               state_q <= StWait;
               wd_q    <= '0;
            end
            StWait: begin
               // A result in the expiry cycle takes priority over the watchdog.
               if (max_valid) begin
                  result_index_q <= max_index;
                  result_value_q <= max_value;
                  result_valid_q <= 1'b1;
                  infer_count_q  <= infer_count_q + CNT_ONE;
                  state_q        <= StDone;
               end else if (wd_expire) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= StDone;
               end else begin
                  wd_q <= wd_q + CNT_ONE;
               end
            end
            StDone: begin
               if (pending_q || trigger) begin
                  state_q   <= StNnRst;
                  rst_cnt_q <= RST_LAST;
                  pending_q <= 1'b0;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign nn_reset     = nn_reset_w;
   assign nn_valid     = nn_valid_w;
   assign busy         = busy_w;
   assign result_index = result_index_q;
   assign result_value = result_value_q;
   assign result_valid = result_valid_q;
   assign timeout_err  = timeout_err_q;
   assign infer_count  = infer_count_q;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Scoreboard bench for nn_infer_sequencer: stimulus pushes expected results,
// a monitor pops and compares them on every result_valid strobe.
module tb_nn_infer_sequencer;

   localparam int unsigned RESET_CYCLES   = 2;
   localparam int unsigned TIMEOUT_CYCLES = 20;

   typedef struct packed {
      logic [3:0]  idx;
      logic [15:0] val;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_toggle = 1'b0;
   logic        start_pulse = 1'b0;
   logic        auto_mode = 1'b0;
   logic        max_valid = 1'b0;
   logic [3:0]  max_index = '0;
   logic [15:0] max_value = '0;
   logic        nn_reset;
   logic        nn_valid;
   logic [3:0]  result_index;
   logic [15:0] result_value;
   logic        result_valid;
   logic        busy;
   logic        timeout_err;
   logic [15:0] infer_count;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_cnt = 0;

   nn_infer_sequencer #(
      .RESET_CYCLES   (RESET_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .IDX_W          (4),
      .VAL_W          (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .frame_toggle (frame_toggle),
      .start_pulse  (start_pulse),
      .auto_mode    (auto_mode),
      .max_valid    (max_valid),
      .max_index    (max_index),
      .max_value    (max_value),
      .nn_reset     (nn_reset),
      .nn_valid     (nn_valid),
      .result_index (result_index),
      .result_value (result_value),
      .result_valid (result_valid),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .infer_count  (infer_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Pops the scoreboard on every result strobe and watches NN handshake rules.
   task automatic monitor();
      int   rst_run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            rst_run = 0;
         end else begin
            if (result_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result_valid", 32'(result_valid), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("result_index", 32'(result_index), 32'(e.idx));
                  check("result_value", 32'(result_value), 32'(e.val));
                  check("infer_count_at_strobe", 32'(infer_count), 32'(e.cnt));
               end
            end
            check("reset_valid_overlap", 32'(nn_reset & nn_valid), 32'd0);
            if (nn_reset) begin
               rst_run++;
            end else if (rst_run != 0) begin
               check("nn_reset_len", 32'(rst_run), 32'(RESET_CYCLES));
               rst_run = 0;
            end
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start_pulse = 1'b1;
      @(posedge clk);
      #1 start_pulse = 1'b0;
   endtask

   task automatic toggle_frame(input logic lvl);
      @(posedge clk);
      #1 frame_toggle = lvl;
   endtask

   // Returns at the falling edge of the RUN cycle (first nn_valid high).
   task automatic wait_run(input string name);
      int n = 0;
      @(negedge clk);
      while (!nn_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!nn_valid) check({name, "_run_wait_expired"}, 32'(nn_valid), 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) check({name, "_idle_wait_expired"}, 32'(busy), 32'd0);
   endtask

   // Present max_valid during WAIT cycle k and record the expected result.
   task automatic respond(input int k, input logic [3:0] idx, input logic [15:0] val);
      exp_t e;
      exp_cnt++;
      e.idx = idx;
      e.val = val;
      e.cnt = 16'(exp_cnt);
      exp_q.push_back(e);
      repeat (k) @(posedge clk);
      #1;
      max_index = idx;
      max_value = val;
      max_valid = 1'b1;
      @(posedge clk);
      #1;
      max_valid = 1'b0;
      max_index = '0;
      max_value = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [3:0]  a_idx [3];
      logic [15:0] a_val [3];
      int          nv;
      a_idx[0] = 4'd1;  a_val[0] = 16'h0100;
      a_idx[1] = 4'd4;  a_val[1] = 16'h0280;
      a_idx[2] = 4'd8;  a_val[2] = 16'hff80;

      fork
         monitor();
      join_none

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_nn_reset", 32'(nn_reset), 32'd0);
      check("rst_nn_valid", 32'(nn_valid), 32'd0);
      check("rst_result_index", 32'(result_index), 32'd0);
      check("rst_result_value", 32'(result_value), 32'd0);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_infer_count", 32'(infer_count), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Frame toggle rising edge, NN answers index 7 value 0x0340.
      toggle_frame(1'b1);
      wait_run("t1");
      respond(10, 4'd7, 16'h0340);
      wait_idle("t1");
      check("t1_infer_count", 32'(infer_count), 32'd1);
      check("t1_timeout_err", 32'(timeout_err), 32'd0);

      // Watchdog expiry: nn_valid high for RUN plus 19 WAIT cycles.
      pulse_start();
      wait_run("t2");
      nv = 1;
      for (int i = 0; i < 300 && busy; i++) begin
         @(negedge clk);
         if (nn_valid) nv++;
      end
      check("t2_busy_fell", 32'(busy), 32'd0);
      check("t2_valid_cycles", 32'(nv), 32'(TIMEOUT_CYCLES));
      check("t2_timeout_err", 32'(timeout_err), 32'd1);
      check("t2_infer_count", 32'(infer_count), 32'd1);
      check("t2_result_index", 32'(result_index), 32'd7);
      check("t2_result_value", 32'(result_value), 32'h0340);

      // max_valid in the exact expiry cycle wins.
      pulse_start();
      wait_run("t3");
      respond(TIMEOUT_CYCLES, 4'd3, 16'h0155);
      wait_idle("t3");
      check("t3_timeout_err", 32'(timeout_err), 32'd0);
      check("t3_infer_count", 32'(infer_count), 32'd2);

      // Three triggers during WAIT give exactly one extra inference.
      pulse_start();
      wait_run("t4a");
      repeat (3) pulse_start();
      respond(4, 4'd2, 16'h0100);
      wait_run("t4b");
      respond(5, 4'd9, 16'h0200);
      wait_idle("t4");
      check("t4_infer_count", 32'(infer_count), 32'd4);
      repeat (10) @(negedge clk);
      check("t4_no_third_run", 32'(busy), 32'd0);

      // Auto mode with falling frame edge: back-to-back passes.
      auto_mode = 1'b1;
      toggle_frame(1'b0);
      for (int p = 0; p < 3; p++) begin
         wait_run("t5");
         if (p == 2) auto_mode = 1'b0;
         respond(10, a_idx[p], a_val[p]);
         if (p < 2) begin
            @(negedge clk);
            check("t5_done_busy", 32'(busy), 32'd1);
            @(negedge clk);
            check("t5_direct_nn_reset", 32'(nn_reset), 32'd1);
         end
      end
      wait_idle("t5");
      check("t5_infer_count", 32'(infer_count), 32'd7);
      repeat (5) @(negedge clk);
      check("t5_stays_idle", 32'(busy), 32'd0);

      // Reset pulse during WAIT aborts immediately with no result strobe.
      pulse_start();
      wait_run("t6");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_nn_valid", 32'(nn_valid), 32'd0);
      check("t6_infer_count", 32'(infer_count), 32'd0);
      check("t6_result_index", 32'(result_index), 32'd0);
      check("t6_result_value", 32'(result_value), 32'd0);
      check("t6_result_valid", 32'(result_valid), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      exp_cnt = 0;
      pulse_start();
      wait_run("t6b");
      respond(10, 4'd5, 16'h0abc);
      wait_idle("t6b");
      check("t6_post_infer_count", 32'(infer_count), 32'd1);
      check("t6_post_timeout_err", 32'(timeout_err), 32'd0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
